// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit for the MIPS execute
// stage. Holds the architectural HI/LO registers and runs a 32-step
// shift-add (multiply) or restoring shift-subtract (divide) on unsigned
// operand magnitudes. A final FIX cycle applies sign correction and writes
// Hi/Lo. Busy covers the whole operation so the pipeline stalls MFHI/MFLO
// and new mult/div instructions until Done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    input  logic [1:0]       Op,
    input  logic             Start,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    // Two's-complement negation of a single word.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double word.
    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x);
        return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; only signed ops look at the sign bit.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic             is_signed);
        if (is_signed && x[WIDTH-1]) begin
            return neg_w(x);
        end else begin
            return x;
        end
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    // Multiply: {partial product high, multiplier}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_r;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic               is_div_r;
    logic               neg_lo_r;    // product or quotient must be negated
    logic               neg_hi_r;    // remainder must be negated
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   hi_fix_s;
    logic [WIDTH-1:0]   lo_fix_s;

    // One iteration of shift-add or restoring shift-subtract on acc_r.
    always_comb begin
        sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        shifted_s = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s    = shifted_s - {1'b0, b_r};
        step_s    = acc_r;
        if (is_div_r) begin
            if (!diff_s[WIDTH]) begin
                step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override for the FIX cycle.
    always_comb begin
        prod_fix_s = neg_lo_r ? neg_dw(acc_r) : acc_r;
        hi_fix_s   = prod_fix_s[2*WIDTH-1:WIDTH];
        lo_fix_s   = prod_fix_s[WIDTH-1:0];
        if (is_div_r) begin
            if (div_zero_r) begin
                hi_fix_s = a_raw_r;
                lo_fix_s = {WIDTH{1'b1}};
            end else begin
                hi_fix_s = neg_hi_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
                lo_fix_s = neg_lo_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            end
        end else begin
            hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM, operand latches, iteration datapath and HI/LO registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            b_r        <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_lo_r   <= 1'b0;
            neg_hi_r   <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // MTHI/MTLO only land while idle; a same-cycle Start
                    // still launches and its result overwrites them later.
                    if (HiWrite) begin
                        hi_r <= WriteData;
                    end else begin
                        hi_r <= hi_r;
                    end
                    if (LoWrite) begin
                        lo_r <= WriteData;
                    end else begin
                        lo_r <= lo_r;
                    end
                    if (Start) begin
                        is_div_r   <= Op[1];
                        a_raw_r    <= Data1;
                        div_zero_r <= (Data2 == {WIDTH{1'b0}});
                        neg_lo_r   <= Op[0] & (Data1[WIDTH-1] ^ Data2[WIDTH-1]);
                        neg_hi_r   <= Op[0] & Data1[WIDTH-1];
                        if (Op[1]) begin
                            acc_r <= {{WIDTH{1'b0}}, mag(Data1, Op[0])};
                            b_r   <= mag(Data2, Op[0]);
                        end else begin
                            acc_r <= {{WIDTH{1'b0}}, mag(Data2, Op[0])};
                            b_r   <= mag(Data1, Op[0]);
                        end
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r <= step_s;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    hi_r    <= hi_fix_s;
                    lo_r    <= lo_fix_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign Hi   = hi_r;
    assign Lo   = lo_r;

endmodule
